sort_host_ctrl: RTL and testbench
=================================

Name: sort_host_ctrl

Overview:
- Hardware host for sorting_top: drives its RAM-load / start / read-back interface, which benches previously drove by hand.
- Accepts DEPTH unsorted words on a valid/ready input stream and writes them into the sorter RAM via WrInit.
- Pulses start, waits for done, then reads the RAM back and emits the sorted words on a valid/ready output stream.
- Sits between a streaming producer/consumer and sorting_top in the sorting subsystem top level.

Parameters:
- N, 8, data width (must match sorting_top N).
- L, 4, sorter address/counter width (must match sorting_top L).
- DEPTH, 8, words per sort job; 2 <= DEPTH <= 2**L.
- TIMEOUT, 1024, maximum cycles in WAIT before abort; 32-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input word valid.
- in_data  in  N  unsorted input word.
- in_ready  out  1  block accepts in_data.
- out_valid  out  1  sorted word valid.
- out_data  out  N  sorted output word, ascending order.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in every state except LOAD with load count 0.
- timeout_err  out  1  sticky; set on WAIT timeout; cleared only by rst.
- s_WrInit  out  1  to sorting_top WrInit.
- s_Rd  out  1  to sorting_top Rd.
- s_RAddr  out  L  to sorting_top RAddr.
- s_DataIn  out  N  to sorting_top DataIn.
- s_start  out  1  to sorting_top start.
- s_DataOut  in  N  from sorting_top DataOut; valid one cycle after s_Rd/s_RAddr are sampled.
- s_done  in  1  from sorting_top done.

Behaviour:
- Reset (async, rst=1): state=LOAD, idx=0, timer=0.
  - All registered outputs are 0: s_WrInit, s_Rd, s_RAddr, s_DataIn, s_start, out_valid, out_data, timeout_err.
  - in_ready=0 while rst=1; busy=0.
- Reset mid-job: same as above. The sorter sees WrInit, Rd and start low immediately; any partial job is discarded.
- Sorter-side outputs are registered; no combinational path from s_done or s_DataOut to any output.
- in_ready = (state==LOAD) && !rst, combinational decode.
- LOAD:
  - On in_valid&&in_ready at edge t: s_WrInit=1, s_RAddr=idx, s_DataIn=in_data for cycle t..t+1; idx++.
  - Without a handshake, s_WrInit=0 and s_RAddr/s_DataIn hold.
  - When the DEPTH-th word is accepted: idx<=0, go to SETTLE.
  - Gaps in in_valid are allowed; in_data is ignored when in_ready=0.
- SETTLE (1 cycle): s_WrInit=0 so the last write lands; then go to WAIT.
- WAIT:
  - s_start=1, held level-high until s_done sampled 1; timer increments each cycle.
  - On s_done=1: s_start<=0, go to RD_ISSUE.
  - If s_done and timer==TIMEOUT-1 occur together, done wins.
  - On timer==TIMEOUT-1 without done: s_start<=0, timeout_err<=1, go to LOAD (idx=0); no output words are produced.
  - s_done already high on WAIT entry is accepted (1-cycle start pulse).
- RD_ISSUE: s_Rd=1, s_RAddr=idx for one cycle; then go to RD_CAPT.
- RD_CAPT: s_Rd<=0; out_data<=s_DataOut; out_valid<=1; go to OUT_WAIT.
- OUT_WAIT:
  - out_valid and out_data hold stable until out_ready=1.
  - On out_valid&&out_ready: out_valid<=0.
  - If idx==DEPTH-1: idx<=0, go to LOAD.
  - Otherwise idx++ and go to RD_ISSUE.
  - out_ready high before out_valid has no effect.
- Throughput: drain takes 3 cycles per word minimum.
- Latency: last input handshake to first out_valid = 1 (SETTLE) + WAIT cycles + 2.
- s_RAddr is a zero-extended idx; idx never exceeds DEPTH-1 (no wrap).
- s_start, s_WrInit and s_Rd are mutually exclusive in every cycle.

Test Plan:
1. Reset, then stream 45,12,78,34,56,89,23,67 with out_ready=1, driving a real sorting_top.
   - s_WrInit pulses at addresses 0..7 with those data; s_start is held until done.
   - Output is 12,23,34,45,56,67,78,89 with out_valid high exactly 8 times; then in_ready=1 and busy=0.
2. Same data with in_valid toggling 1-0-1 and out_ready low for 5 cycles on the 3rd output word.
   - No loss or duplication; out_data=34 held stable throughout the stall.
3. Sorter model that never asserts done, TIMEOUT=16.
   - s_start is high exactly 16 cycles, then timeout_err=1 and state returns to LOAD.
   - No out_valid; timeout_err stays 1 through a subsequent normal job.
4. Assert rst during WAIT and again during OUT_WAIT after 3 outputs.
   - All outputs go 0 within the same cycle (async); a subsequent full job with 8,7,6,5,4,3,2,1 outputs 1..8.
5. Back-to-back jobs: a second job (200,0,255,1,128,127,2,254) is offered while the first drains.
   - in_ready stays 0 until the first drain completes; the second job outputs 0,1,2,127,128,200,254,255.
6. Assertion checks over all tests:
   - s_start, s_WrInit and s_Rd are never high in the same cycle.
   - s_RAddr < DEPTH whenever s_WrInit or s_Rd is high.
   - out_data is stable while out_valid && !out_ready.

Source files
------------

// File: rtl/sort_host_if.sv
// Stream and sorter-side signal bundle for sort_host_ctrl.
// master = the host controller; slave = producer/consumer/sorter side.
interface sort_host_if #(
  parameter int N = 8,
  parameter int L = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         busy;
  logic         timeout_err;
  logic         s_WrInit;
  logic         s_Rd;
  logic [L-1:0] s_RAddr;
  logic [N-1:0] s_DataIn;
  logic         s_start;
  logic [N-1:0] s_DataOut;
  logic         s_done;

  modport master (
    input  in_valid, in_data, out_ready, s_DataOut, s_done,
    output in_ready, out_valid, out_data, busy, timeout_err,
           s_WrInit, s_Rd, s_RAddr, s_DataIn, s_start
  );

  modport slave (
    output in_valid, in_data, out_ready, s_DataOut, s_done,
    input  in_ready, out_valid, out_data, busy, timeout_err,
           s_WrInit, s_Rd, s_RAddr, s_DataIn, s_start
  );
endinterface

// File: rtl/sort_host_ctrl.sv
// Host controller for sorting_top: loads DEPTH words, runs the sort,
// then streams the sorted RAM contents back out.
module sort_host_ctrl #(
  parameter int N       = 8,
  parameter int L       = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  sort_host_if.master bus
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_SETTLE,
    S_WAIT,
    S_RD_ISSUE,
    S_RD_CAPT,
    S_OUT_WAIT
  } state_t;

  localparam logic [L-1:0] LAST_IDX = L'(DEPTH - 1);
  localparam logic [31:0]  TMO_LAST = 32'(TIMEOUT - 1);

  state_t       state_q;
  logic [L-1:0] idx_q;
  logic [31:0]  timer_q;
  logic         wr_q;
  logic         rd_q;
  logic         start_q;
  logic [L-1:0] raddr_q;
  logic [N-1:0] din_q;
  logic         ovalid_q;
  logic [N-1:0] odata_q;
  logic         terr_q;

  // Sorter strobes are set on the transition into the state that owns them,
  // so each one is a clean registered level for exactly that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOAD;
      idx_q    <= '0;
      timer_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      start_q  <= 1'b0;
      raddr_q  <= '0;
      din_q    <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      terr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (bus.in_valid) begin
            wr_q    <= 1'b1;
            raddr_q <= idx_q;
            din_q   <= bus.in_data;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= S_SETTLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            wr_q <= 1'b0;
          end
        end
        S_SETTLE: begin
          wr_q    <= 1'b0;
          start_q <= 1'b1;
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over an expiring timer
          if (bus.s_done) begin
            start_q <= 1'b0;
            rd_q    <= 1'b1;
            raddr_q <= idx_q;
            state_q <= S_RD_ISSUE;
          end else if (timer_q == TMO_LAST) begin
            start_q <= 1'b0;
            terr_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= S_LOAD;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RD_ISSUE: begin
          rd_q    <= 1'b0;
          state_q <= S_RD_CAPT;
        end
        S_RD_CAPT: begin
          odata_q  <= bus.s_DataOut;
          ovalid_q <= 1'b1;
          state_q  <= S_OUT_WAIT;
        end
        S_OUT_WAIT: begin
          if (bus.out_ready) begin
            ovalid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= S_LOAD;
            end else begin
              idx_q   <= idx_q + 1'b1;
              rd_q    <= 1'b1;
              raddr_q <= idx_q + 1'b1;
              state_q <= S_RD_ISSUE;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == S_LOAD) && !rst;
  assign bus.busy        = !((state_q == S_LOAD) && (idx_q == '0));
  assign bus.s_WrInit    = wr_q;
  assign bus.s_Rd        = rd_q;
  assign bus.s_start     = start_q;
  assign bus.s_RAddr     = raddr_q;
  assign bus.s_DataIn    = din_q;
  assign bus.out_valid   = ovalid_q;
  assign bus.out_data    = odata_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_sort_host_ctrl.sv
// Bench for sort_host_ctrl with a behavioural sorter RAM model and an
// output scoreboard of known sorted results.
module tb_sort_host_ctrl;

  localparam int N        = 8;
  localparam int L        = 4;
  localparam int DEPTH    = 8;
  localparam int TMO      = 16;
  localparam int SORT_LAT = 3;

  typedef logic [N-1:0] arr_t [DEPTH];

  localparam arr_t JOB_A = '{8'd45, 8'd12, 8'd78, 8'd34, 8'd56, 8'd89, 8'd23, 8'd67};
  localparam arr_t EXP_A = '{8'd12, 8'd23, 8'd34, 8'd45, 8'd56, 8'd67, 8'd78, 8'd89};
  localparam arr_t JOB_B = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  localparam arr_t EXP_B = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
  localparam arr_t JOB_E = '{8'd200, 8'd0, 8'd255, 8'd1, 8'd128, 8'd127, 8'd2, 8'd254};
  localparam arr_t EXP_E = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd200, 8'd254, 8'd255};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sort_host_if #(.N(N), .L(L)) bus ();

  sort_host_ctrl #(.N(N), .L(L), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           checks = 0;
  int           failures = 0;
  logic [N-1:0] expq [$];
  int           out_cnt = 0;
  int           start_total = 0;
  bit           never_done = 1'b0;
  bit           prev_stall = 1'b0;
  logic [N-1:0] prev_data = '0;
  arr_t         mem;
  int           scnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic arr_t sort_arr(input arr_t a);
    arr_t r = a;
    logic [N-1:0] t;
    for (int i = 1; i < DEPTH; i++)
      for (int j = i; j > 0 && r[j-1] > r[j]; j--) begin
        t = r[j]; r[j] = r[j-1]; r[j-1] = t;
      end
    return r;
  endfunction

  // Sorter model: WrInit writes, Rd returns data next cycle, done after SORT_LAT.
  always @(posedge clk) begin
    if (rst) begin
      bus.s_done    <= 1'b0;
      bus.s_DataOut <= '0;
      scnt          <= 0;
    end else begin
      if (bus.s_WrInit) mem[bus.s_RAddr[2:0]] <= bus.s_DataIn;
      if (bus.s_Rd) bus.s_DataOut <= mem[bus.s_RAddr[2:0]];
      if (!bus.s_start) begin
        scnt       <= 0;
        bus.s_done <= 1'b0;
      end else if (!never_done && !bus.s_done) begin
        if (scnt == SORT_LAT) begin
          mem        <= sort_arr(mem);
          bus.s_done <= 1'b1;
        end else begin
          scnt <= scnt + 1;
        end
      end
    end
  end

  // Per-cycle protocol checks and output scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      chk("strobe_excl", 32'($countones({bus.s_start, bus.s_WrInit, bus.s_Rd}) <= 1), 32'd1);
      if (bus.s_WrInit || bus.s_Rd)
        chk("raddr_range", 32'(int'(bus.s_RAddr) < DEPTH), 32'd1);
      if (prev_stall)
        chk("stall_stable", 32'(bus.out_data), 32'(prev_data));
      if (bus.s_start) start_total <= start_total + 1;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) chk("out_unexpected", 32'd1, 32'd0);
        else chk("out_data", 32'(bus.out_data), 32'(expq.pop_front()));
        out_cnt <= out_cnt + 1;
      end
      prev_stall <= bus.out_valid && !bus.out_ready;
      prev_data  <= bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string t);
    chk({t, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({t, "_busy"}, 32'(bus.busy), 32'd0);
    chk({t, "_wrinit"}, 32'(bus.s_WrInit), 32'd0);
    chk({t, "_rd"}, 32'(bus.s_Rd), 32'd0);
    chk({t, "_start"}, 32'(bus.s_start), 32'd0);
    chk({t, "_raddr"}, 32'(bus.s_RAddr), 32'd0);
    chk({t, "_datain"}, 32'(bus.s_DataIn), 32'd0);
    chk({t, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({t, "_out_data"}, 32'(bus.out_data), 32'd0);
    chk({t, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
  endtask

  task automatic send_job(input arr_t d, input arr_t e, input bit push, input bit gap);
    int n;
    if (push) for (int i = 0; i < DEPTH; i++) expq.push_back(e[i]);
    for (int i = 0; i < DEPTH; i++) begin
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      do begin
        @(negedge clk);
        n++;
      end while (!bus.in_ready && n < 400);
      if (!bus.in_ready) begin
        chk("load_handshake_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
      tick();
      chk("wr_en", 32'(bus.s_WrInit), 32'd1);
      chk("wr_addr", 32'(bus.s_RAddr), 32'(i));
      chk("wr_data", 32'(bus.s_DataIn), 32'(d[i]));
      bus.in_valid = 1'b0;
      if (gap && i < DEPTH - 1) begin
        bus.in_data = ~d[i];
        tick();
        chk("wr_gap", 32'(bus.s_WrInit), 32'd0);
      end
    end
  endtask

  task automatic wait_out(input int target, input string tag);
    int n = 0;
    while (out_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(out_cnt >= target), 32'd1);
  endtask

  task automatic wait_sig_valid(input string tag);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    int obase;
    int sbase;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_reset_busy", 32'(bus.busy), 32'd0);

    // Basic job, consumer always ready
    obase = out_cnt;
    sbase = start_total;
    send_job(JOB_A, EXP_A, 1'b1, 1'b0);
    wait_out(obase + 8, "t1_drain");
    tick();
    chk("t1_start_cycles", 32'(start_total - sbase), 32'(SORT_LAT + 2));
    chk("t1_out_count", 32'(out_cnt - obase), 32'd8);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd0);

    // Gapped input, consumer stall on third word
    obase = out_cnt;
    send_job(JOB_A, EXP_A, 1'b1, 1'b1);
    wait_out(obase + 2, "t2_first_two");
    bus.out_ready = 1'b0;
    wait_sig_valid("t2_third_valid");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_stall_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_stall_data", 32'(bus.out_data), 32'd34);
    end
    bus.out_ready = 1'b1;
    wait_out(obase + 8, "t2_drain");
    tick();
    chk("t2_out_count", 32'(out_cnt - obase), 32'd8);
    chk("t2_queue_empty", 32'(expq.size()), 32'd0);

    // Sorter never finishes
    never_done = 1'b1;
    obase = out_cnt;
    sbase = start_total;
    send_job(JOB_A, EXP_A, 1'b0, 1'b0);
    n = 0;
    while (!bus.timeout_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t3_timeout_set", 32'(bus.timeout_err), 32'd1);
    tick();
    chk("t3_start_cycles", 32'(start_total - sbase), 32'(TMO));
    chk("t3_start_low", 32'(bus.s_start), 32'd0);
    chk("t3_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t3_busy", 32'(bus.busy), 32'd0);
    repeat (5) tick();
    chk("t3_no_output", 32'(out_cnt - obase), 32'd0);
    never_done = 1'b0;
    obase = out_cnt;
    send_job(JOB_A, EXP_A, 1'b1, 1'b0);
    wait_out(obase + 8, "t3_normal_drain");
    tick();
    chk("t3_timeout_sticky", 32'(bus.timeout_err), 32'd1);

    // Reset during WAIT
    send_job(JOB_B, EXP_B, 1'b0, 1'b0);
    n = 0;
    while (!bus.s_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_in_wait", 32'(bus.s_start), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk_idle("t4_rst_wait");
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Reset during OUT_WAIT after three outputs
    obase = out_cnt;
    send_job(JOB_A, EXP_A, 1'b1, 1'b0);
    wait_out(obase + 3, "t4_three_out");
    bus.out_ready = 1'b0;
    wait_sig_valid("t4_fourth_valid");
    #2;
    rst = 1'b1;
    #1;
    chk_idle("t4_rst_outwait");
    expq.delete();
    @(negedge clk);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    obase = out_cnt;
    send_job(JOB_B, EXP_B, 1'b1, 1'b0);
    wait_out(obase + 8, "t4_after_reset_drain");
    tick();
    chk("t4_queue_empty", 32'(expq.size()), 32'd0);

    // Back-to-back: second job offered while the first drains
    obase = out_cnt;
    send_job(JOB_A, EXP_A, 1'b1, 1'b0);
    fork
      send_job(JOB_E, EXP_E, 1'b1, 1'b0);
      begin : guard
        int  g;
        bit  early;
        g = 0;
        early = 1'b0;
        while (out_cnt < obase + 8 && g < 400) begin
          @(negedge clk);
          if (bus.in_ready && out_cnt < obase + 8) early = 1'b1;
          g++;
        end
        chk("t5_in_ready_held", 32'(early), 32'd0);
      end
    join
    wait_out(obase + 16, "t5_drain");
    tick();
    chk("t5_out_count", 32'(out_cnt - obase), 32'd16);
    chk("t5_queue_empty", 32'(expq.size()), 32'd0);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t5_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
